// File: rtl/mp_pkg.sv
// Shared definitions for the multi-precision add/sub datapath: default widths
// common to mp_adder and mp_operand_loader, and the loader state encoding.
package mp_pkg;

    localparam int MP_OPERAND_WIDTH = 128;
    localparam int MP_WORD_WIDTH    = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT_DONE
    } loaderState_e;

endpackage

// File: rtl/mp_word_packer.sv
// Assembles an OPERAND_WIDTH register from WORD_WIDTH slices written by index.
// MP_LOADER_MSW_FIRST_EN: index 0 lands in the most-significant slice.
module mp_word_packer
    import mp_pkg::*;
#(
    parameter int OPERAND_WIDTH = MP_OPERAND_WIDTH,
    parameter int WORD_WIDTH    = MP_WORD_WIDTH,
    parameter int N             = OPERAND_WIDTH / WORD_WIDTH,
    parameter int IDX_W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iWe,
    input  logic [IDX_W-1:0]         iIdx,
    input  logic [WORD_WIDTH-1:0]    iWord,
    output logic [OPERAND_WIDTH-1:0] oOperand
);

    // NOTE: sequential state is written with <= only, so every reader of
    // oOperand sees the pre-edge value regardless of process ordering.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oOperand <= '0;
        end else if (iWe) begin
            for (int k = 0; k < N; k++) begin
`ifdef MP_LOADER_MSW_FIRST_EN
                if (iIdx == IDX_W'(N - 1 - k)) begin
`else
                if (iIdx == IDX_W'(k)) begin
`endif
                    oOperand[k*WORD_WIDTH +: WORD_WIDTH] <= iWord;
                end
            end
        end
    end

endmodule

// File: rtl/mp_operand_loader.sv
// Collects a command plus two word-serial operands and launches mp_adder.
// MP_LOADER_MSW_FIRST_EN (in mp_word_packer) selects most-significant word first.
module mp_operand_loader
    import mp_pkg::*;
#(
    parameter int OPERAND_WIDTH = MP_OPERAND_WIDTH,
    parameter int WORD_WIDTH    = MP_WORD_WIDTH
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iCmdValid,
    input  logic                     iCmdSub,
    output logic                     oCmdReady,
    input  logic                     iWordValid,
    input  logic [WORD_WIDTH-1:0]    iWord,
    output logic                     oWordReady,
    output logic                     oStart,
    output logic                     oSub,
    output logic [OPERAND_WIDTH-1:0] oOpA,
    output logic [OPERAND_WIDTH-1:0] oOpB,
    input  logic                     iAdderDone,
    output logic                     oBusy
);

    localparam int N = OPERAND_WIDTH / WORD_WIDTH;
    // A single-word operand still needs a one-bit index port.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    loaderState_e     state, stateNext;
    logic [IDX_W-1:0] wordCnt;
    logic             sub;
    logic             cmdFire, wordFire, lastWord;

    assign cmdFire  = iCmdValid & oCmdReady;
    assign wordFire = iWordValid & oWordReady;
    assign lastWord = (wordCnt == IDX_W'(N - 1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            wordCnt <= '0;
            sub     <= 1'b0;
        end else begin
            state <= stateNext;
            if (cmdFire) begin
                sub     <= iCmdSub;
                wordCnt <= '0;
            end else if (wordFire) begin
                wordCnt <= lastWord ? '0 : wordCnt + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stateNext  = state;
        oCmdReady  = 1'b0;
        oWordReady = 1'b0;
        oStart     = 1'b0;
        case (state)
            IDLE: begin
                oCmdReady = 1'b1;
                if (iCmdValid) stateNext = LOAD_A;
            end
            LOAD_A: begin
                oWordReady = 1'b1;
                if (iWordValid && lastWord) stateNext = LOAD_B;
            end
            LOAD_B: begin
                oWordReady = 1'b1;
                if (iWordValid && lastWord) stateNext = START;
            end
            START: begin
                oStart    = 1'b1;
                stateNext = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (iAdderDone) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign oBusy = (state != IDLE);
    assign oSub  = sub;

    mp_word_packer #(
        .OPERAND_WIDTH(OPERAND_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) uPackA (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWe     (wordFire && (state == LOAD_A)),
        .iIdx    (wordCnt),
        .iWord   (iWord),
        .oOperand(oOpA)
    );

    mp_word_packer #(
        .OPERAND_WIDTH(OPERAND_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH)
    ) uPackB (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWe     (wordFire && (state == LOAD_B)),
        .iIdx    (wordCnt),
        .iWord   (iWord),
        .oOperand(oOpB)
    );

endmodule

// File: tb/tb_mp_operand_loader.sv
// Self-checking bench for mp_operand_loader at default widths (4 x 32-bit words).
// Honours MP_LOADER_MSW_FIRST_EN when building expected operands.
module tb_mp_operand_loader;

    localparam int OPW = 128;
    localparam int WW  = 32;

    logic            iClk = 1'b0;
    logic            iRst, iCmdValid, iCmdSub, iWordValid, iAdderDone;
    logic [WW-1:0]   iWord;
    logic            oCmdReady, oWordReady, oStart, oSub, oBusy;
    logic [OPW-1:0]  oOpA, oOpB;

    int checks = 0;
    int errors = 0;
    int startCount = 0;

    always #5 iClk = ~iClk;

    mp_operand_loader #(.OPERAND_WIDTH(OPW), .WORD_WIDTH(WW)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iCmdValid (iCmdValid),
        .iCmdSub   (iCmdSub),
        .oCmdReady (oCmdReady),
        .iWordValid(iWordValid),
        .iWord     (iWord),
        .oWordReady(oWordReady),
        .oStart    (oStart),
        .oSub      (oSub),
        .oOpA      (oOpA),
        .oOpB      (oOpB),
        .iAdderDone(iAdderDone),
        .oBusy     (oBusy)
    );

    // oStart is stable between edges; count pulses away from the active edge.
    always @(negedge iClk) if (oStart === 1'b1) startCount++;

    typedef struct packed {
        logic          cmdValid;
        logic          cmdSub;
        logic          wordValid;
        logic [WW-1:0] word;
        logic          adderDone;
        logic [3:0]    expFlags;   // {oCmdReady, oWordReady, oStart, oBusy}
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OPW-1:0] packOp(input logic [WW-1:0] w[8], input int base);
        logic [OPW-1:0] r = '0;
        for (int k = 0; k < 4; k++) begin
`ifdef MP_LOADER_MSW_FIRST_EN
            r[(3-k)*WW +: WW] = w[base+k];
`else
            r[k*WW +: WW] = w[base+k];
`endif
        end
        return r;
    endfunction

    // Offer a command until accepted; handshake completes on the next edge.
    task automatic doCmd(input logic sub);
        int n = 0;
        bit got = 0;
        while (!got && n < 20) begin
            @(negedge iClk);
            iCmdValid = 1'b1;
            iCmdSub   = sub;
            #1;
            got = (oCmdReady === 1'b1);
            n++;
        end
        check("cmdAccepted", got, 1'b1);
    endtask

    // Feed count words (A then B), optionally toggling iWordValid each cycle.
    task automatic sendWords(input logic [WW-1:0] w[8], input int count, input bit toggle);
        int idx = 0;
        int cyc = 0;
        bit phase = 1'b0;
        while (idx < count && cyc < 200) begin
            @(negedge iClk);
            iCmdValid  = 1'b0;
            phase      = toggle ? ~phase : 1'b1;
            iWordValid = phase;
            iWord      = phase ? w[idx] : 32'hBAD0_0BAD;
            #1;
            if (phase && oWordReady === 1'b1) idx++;
            cyc++;
        end
        check("wordsAccepted", idx, count);
    endtask

    logic [WW-1:0]  wSub[8], wRst[8], wNew[8];
    logic [OPW-1:0] expA, expB;
    int             base;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wSub = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
        wRst = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004,
                 32'hDEAD_0005, 32'hDEAD_0006, 32'hDEAD_0007, 32'hDEAD_0008};
        wNew = '{32'h0000_000A, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000,
                 32'h0000_0005, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0001};

        // Add transaction, one row per cycle, then WAIT_DONE with offers held high.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 4'b1000};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 4'b0101};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h3,        1'b0, 4'b0101};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h2,        1'b1, 4'b0101};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 4'b0101};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 4'b0101};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h7,        1'b0, 4'b0101};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h6,        1'b0, 4'b0101};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h5,        1'b0, 4'b0101};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'b0011};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0001};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0001};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b0001};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 4'b1000};

        // Reset with a command offered: reset must win.
        iRst = 1'b1; iCmdValid = 1'b1; iCmdSub = 1'b1;
        iWordValid = 1'b0; iWord = '0; iAdderDone = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0; iCmdValid = 1'b0; iCmdSub = 1'b0;
        #1;
        check("resetFlags", {oCmdReady, oWordReady, oStart, oBusy}, 4'b1000);
        check("resetOpA", oOpA, '0);
        check("resetOpB", oOpB, '0);
        check("resetSub", oSub, 1'b0);

        for (int i = 0; i < 14; i++) begin
            @(negedge iClk);
            iCmdValid  = vecs[i].cmdValid;
            iCmdSub    = vecs[i].cmdSub;
            iWordValid = vecs[i].wordValid;
            iWord      = vecs[i].word;
            iAdderDone = vecs[i].adderDone;
            #1;
            check($sformatf("vecFlags[%0d]", i), {oCmdReady, oWordReady, oStart, oBusy}, vecs[i].expFlags);
        end
`ifdef MP_LOADER_MSW_FIRST_EN
        expA = 128'h00000004_00000003_00000002_00000001;
        expB = 128'h00000008_00000007_00000006_00000005;
`else
        expA = 128'h00000001_00000002_00000003_00000004;
        expB = 128'h00000005_00000006_00000007_00000008;
`endif
        check("addOpA", oOpA, expA);
        check("addOpB", oOpB, expB);
        check("addSub", oSub, 1'b0);
        check("addStartCount", startCount, 1);

        // Subtract with iWordValid toggling every other cycle.
        base = startCount;
        doCmd(1'b1);
        sendWords(wSub, 8, 1'b1);
        @(negedge iClk);
        iWordValid = 1'b0;
        #1;
        check("subStart", oStart, 1'b1);
        repeat (4) @(negedge iClk);
        iAdderDone = 1'b1;
        #1;
        check("subWaitBusy", {oCmdReady, oBusy}, 2'b01);
        @(negedge iClk);
        iAdderDone = 1'b0;
        #1;
        check("subDoneReady", oCmdReady, 1'b1);
        check("subOpA", oOpA, packOp(wSub, 0));
        check("subOpB", oOpB, packOp(wSub, 4));
        check("subSub", oSub, 1'b1);
        check("subStartCount", startCount - base, 1);

        // Reset after two A words abandons the load.
        doCmd(1'b0);
        sendWords(wRst, 2, 1'b0);
        @(negedge iClk);
        iRst = 1'b1; iCmdValid = 1'b1; iWordValid = 1'b1;
        @(negedge iClk);
        iRst = 1'b0; iCmdValid = 1'b0; iWordValid = 1'b0;
        #1;
        check("midRstFlags", {oCmdReady, oWordReady, oStart, oBusy}, 4'b1000);
        check("midRstOpA", oOpA, '0);
        check("midRstOpB", oOpB, '0);
        check("midRstSub", oSub, 1'b0);
        base = startCount;
        repeat (10) @(negedge iClk);
        check("midRstNoStart", startCount - base, 0);

        // Fresh command loads correctly after the abandoned one.
        doCmd(1'b1);
        sendWords(wNew, 8, 1'b0);
        @(negedge iClk);
        iWordValid = 1'b0;
        #1;
        check("newStart", oStart, 1'b1);
        check("newOpA", oOpA, packOp(wNew, 0));
        check("newOpB", oOpB, packOp(wNew, 4));
        check("newSub", oSub, 1'b1);
        @(negedge iClk);
        iAdderDone = 1'b1;
        @(negedge iClk);
        iAdderDone = 1'b0;
        #1;
        check("newIdle", {oCmdReady, oBusy}, 2'b10);
        check("newStartCount", startCount - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
